// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit.
// Contents: opcode values (IR[31:27]), control-step encodings, bit positions
// of the 40-bit control word, and the last-step lookup per opcode.
package mini_src_pkg;

    localparam int OPW   = 5;
    localparam int STEPW = 3;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPW-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_BR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_JAL  = 5'b10101;
    localparam logic [OPW-1:0] OP_IN   = 5'b10110;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    // T1 is split into T1A (PC update, single pulse) and T1W (memory read,
    // may be held), so the step register needs one extra bit.
    typedef enum logic [STEPW:0] {
        S_T0  = 4'd0,
        S_T1A = 4'd1,
        S_T1W = 4'd2,
        S_T2  = 4'd3,
        S_T3  = 4'd4,
        S_T4  = 4'd5,
        S_T5  = 4'd6,
        S_T6  = 4'd7,
        S_T7  = 4'd8
    } step_t;

    localparam int CW_W = 40;
    // bus drivers
    localparam int CW_PCOUT = 0,  CW_ZLOWOUT = 1,  CW_ZHIGHOUT = 2,  CW_MDROUT = 3,  CW_HIOUT = 4;
    localparam int CW_LOOUT = 5,  CW_INPORTOUT = 6, CW_COUT = 7,     CW_BAOUT = 8,   CW_ROUT = 9;
    // register loads
    localparam int CW_PCIN = 10,  CW_INCPC = 11,   CW_MARIN = 12,    CW_MDRIN = 13,  CW_IRIN = 14;
    localparam int CW_YIN = 15,   CW_ZIN = 16,     CW_HIIN = 17,     CW_LOIN = 18,   CW_CONIN = 19;
    localparam int CW_OUTPORTIN = 20, CW_RIN = 21;
    // register select and memory strobes
    localparam int CW_GRA = 22,   CW_GRB = 23,     CW_GRC = 24,      CW_READ = 25,   CW_WRITE = 26;
    // ALU operation
    localparam int CW_ADD = 27,   CW_SUB = 28,     CW_AND = 29,      CW_OR = 30,     CW_SHR = 31;
    localparam int CW_SHRA = 32,  CW_SHL = 33,     CW_ROR = 34,      CW_ROL = 35,    CW_MUL = 36;
    localparam int CW_DIV = 37,   CW_NEG = 38,     CW_NOT = 39;

    // Final execute step of each instruction; nop, halt and undefined
    // opcodes finish with the fetch.
    function automatic step_t last_step(input logic [OPW-1:0] op);
        case (op)
            OP_LD, OP_ST:                                    return S_T7;
            OP_MUL, OP_DIV, OP_BR:                           return S_T6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
            OP_ADDI, OP_ANDI, OP_ORI:                        return S_T5;
            OP_NEG, OP_NOT, OP_JAL:                          return S_T4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:          return S_T3;
            default:                                         return S_T2;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational decoder: (step, opcode, CON_FF) -> 40-bit control word.
// Ports:
//   step    in  current control step (T0, T1A, T1W, T2..T7)
//   opcode  in  IR[31:27]
//   con_ff  in  branch condition, only consulted in br T6
//   cw      out control word, bit positions from mini_src_pkg
module control_decode
    import mini_src_pkg::*;
(
    input  step_t             step,
    input  logic [OPW-1:0]    opcode,
    input  logic              con_ff,
    output logic [CW_W-1:0]   cw
);

    // ALU function selected by the opcode itself (R-type, immediate,
    // mul/div, neg/not); empty for every other opcode.
    logic [CW_W-1:0] alu_word;

    always_comb begin
        alu_word = '0;
        case (opcode)
            OP_ADD, OP_ADDI: alu_word[CW_ADD]  = 1'b1;
            OP_SUB:          alu_word[CW_SUB]  = 1'b1;
            OP_AND, OP_ANDI: alu_word[CW_AND]  = 1'b1;
            OP_OR, OP_ORI:   alu_word[CW_OR]   = 1'b1;
            OP_ROR:          alu_word[CW_ROR]  = 1'b1;
            OP_ROL:          alu_word[CW_ROL]  = 1'b1;
            OP_SHR:          alu_word[CW_SHR]  = 1'b1;
            OP_SHRA:         alu_word[CW_SHRA] = 1'b1;
            OP_SHL:          alu_word[CW_SHL]  = 1'b1;
            OP_MUL:          alu_word[CW_MUL]  = 1'b1;
            OP_DIV:          alu_word[CW_DIV]  = 1'b1;
            OP_NEG:          alu_word[CW_NEG]  = 1'b1;
            OP_NOT:          alu_word[CW_NOT]  = 1'b1;
            default:         alu_word = '0;
        endcase
    end

    always_comb begin
        cw = '0;
        case (step)
            S_T0: begin
                cw[CW_PCOUT] = 1'b1; cw[CW_MARIN] = 1'b1; cw[CW_INCPC] = 1'b1; cw[CW_ZIN] = 1'b1;
            end
            S_T1A: begin
                cw[CW_ZLOWOUT] = 1'b1; cw[CW_PCIN] = 1'b1;
            end
            S_T1W: begin
                cw[CW_READ] = 1'b1; cw[CW_MDRIN] = 1'b1;
            end
            S_T2: begin
                cw[CW_MDROUT] = 1'b1; cw[CW_IRIN] = 1'b1;
            end
            S_T3: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        cw[CW_GRB] = 1'b1; cw[CW_BAOUT] = 1'b1; cw[CW_YIN] = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        cw[CW_GRB] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_YIN] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        cw[CW_GRA] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_YIN] = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin
                        cw = alu_word; cw[CW_GRB] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_ZIN] = 1'b1;
                    end
                    OP_BR:   begin cw[CW_GRA] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_CONIN] = 1'b1; end
                    OP_JR:   begin cw[CW_GRA] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_PCIN] = 1'b1; end
                    OP_JAL:  begin cw[CW_PCOUT] = 1'b1; cw[CW_GRB] = 1'b1; cw[CW_RIN] = 1'b1; end
                    OP_MFHI: begin cw[CW_HIOUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_RIN] = 1'b1; end
                    OP_MFLO: begin cw[CW_LOOUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_RIN] = 1'b1; end
                    OP_IN:   begin cw[CW_INPORTOUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_RIN] = 1'b1; end
                    OP_OUT:  begin cw[CW_GRA] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_OUTPORTIN] = 1'b1; end
                    default: cw = '0;
                endcase
            end
            S_T4: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        cw[CW_COUT] = 1'b1; cw[CW_ADD] = 1'b1; cw[CW_ZIN] = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
                        cw = alu_word; cw[CW_GRC] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_ZIN] = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        cw = alu_word; cw[CW_COUT] = 1'b1; cw[CW_ZIN] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        cw = alu_word; cw[CW_GRB] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_ZIN] = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin cw[CW_ZLOWOUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_RIN] = 1'b1; end
                    OP_BR:          begin cw[CW_PCOUT] = 1'b1; cw[CW_YIN] = 1'b1; end
                    OP_JAL:         begin cw[CW_GRA] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_PCIN] = 1'b1; end
                    default: cw = '0;
                endcase
            end
            S_T5: begin
                case (opcode)
                    OP_LD, OP_ST: begin cw[CW_ZLOWOUT] = 1'b1; cw[CW_MARIN] = 1'b1; end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        cw[CW_ZLOWOUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_RIN] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin cw[CW_ZLOWOUT] = 1'b1; cw[CW_LOIN] = 1'b1; end
                    OP_BR:          begin cw[CW_COUT] = 1'b1; cw[CW_ADD] = 1'b1; cw[CW_ZIN] = 1'b1; end
                    default: cw = '0;
                endcase
            end
            S_T6: begin
                case (opcode)
                    OP_LD:          begin cw[CW_READ] = 1'b1; cw[CW_MDRIN] = 1'b1; end
                    OP_ST:          begin cw[CW_GRA] = 1'b1; cw[CW_ROUT] = 1'b1; cw[CW_MDRIN] = 1'b1; end
                    OP_MUL, OP_DIV: begin cw[CW_ZHIGHOUT] = 1'b1; cw[CW_HIIN] = 1'b1; end
                    // Branch target is always driven; PC only loads when taken.
                    OP_BR:          begin cw[CW_ZLOWOUT] = 1'b1; cw[CW_PCIN] = con_ff; end
                    default: cw = '0;
                endcase
            end
            S_T7: begin
                case (opcode)
                    OP_LD:   begin cw[CW_MDROUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_RIN] = 1'b1; end
                    OP_ST:   cw[CW_WRITE] = 1'b1;
                    default: cw = '0;
                endcase
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini SRC DataPath. Steps through fetch
// (T0, T1A, T1W, T2) and the opcode's execute steps, stalls memory steps
// until Mem_Ready, and stops at an instruction boundary on HALT or Stop.
// Ports:
//   Clock, Clear_n (synchronous, active-low)
//   IR[31:0]   instruction register (only IR[31:27] used)
//   CON_FF     branch condition; Mem_Ready completes Read/Write steps
//   Stop       level request to halt at the next instruction boundary
//   Run        1 while executing, 0 once halted
//   remaining outputs: DataPath bus drivers, register loads, register
//   selects, memory strobes and one-hot ALU operation
// The end-of-fetch decision for nop/halt is taken at the T2 edge, so IR
// must already present the instruction being fetched by the end of T2.
module control_sequencer
    import mini_src_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear_n,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Mem_Ready,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
    output logic        PCin, IncPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortIn, Rin,
    output logic        Gra, Grb, Grc, Read, Write,
    output logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT
);

    step_t           step_reg, step_next;
    logic            run_reg, run_next;
    // Set while Clear_n is sampled low; keeps outputs quiet until the first
    // edge after release, after which T0 is shown.
    logic            hold_reg;
    logic [OPW-1:0]  opcode;
    logic [CW_W-1:0] cw_raw, cw;
    logic            active, mem_wait, at_end;
    logic            unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    control_decode u_decode (
        .step   (step_reg),
        .opcode (opcode),
        .con_ff (CON_FF),
        .cw     (cw_raw)
    );

    always_comb begin
        active    = run_reg && !hold_reg;
        cw        = active ? cw_raw : '0;
        mem_wait  = (cw[CW_READ] || cw[CW_WRITE]) && !Mem_Ready;
        at_end    = (step_reg == last_step(opcode));
        step_next = step_reg;
        run_next  = run_reg;
        if (active && !mem_wait) begin
            // T7 (or any unused encoding) can only ever fall back to T0.
            if (at_end || step_reg >= S_T7) begin
                step_next = S_T0;
                if (Stop || opcode == OP_HALT) begin
                    run_next = 1'b0;
                end
            end else begin
                step_next = step_t'(step_reg + 4'd1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Clear_n) begin
            step_reg <= S_T0;
            run_reg  <= 1'b1;
            hold_reg <= 1'b1;
        end else begin
            step_reg <= step_next;
            run_reg  <= run_next;
            hold_reg <= 1'b0;
        end
    end

    assign Run       = run_reg;
    assign PCout     = cw[CW_PCOUT];
    assign Zlowout   = cw[CW_ZLOWOUT];
    assign Zhighout  = cw[CW_ZHIGHOUT];
    assign MDRout    = cw[CW_MDROUT];
    assign HIout     = cw[CW_HIOUT];
    assign LOout     = cw[CW_LOOUT];
    assign InPortout = cw[CW_INPORTOUT];
    assign Cout      = cw[CW_COUT];
    assign BAout     = cw[CW_BAOUT];
    assign Rout      = cw[CW_ROUT];
    assign PCin      = cw[CW_PCIN];
    assign IncPC     = cw[CW_INCPC];
    assign MARin     = cw[CW_MARIN];
    assign MDRin     = cw[CW_MDRIN];
    assign IRin      = cw[CW_IRIN];
    assign Yin       = cw[CW_YIN];
    assign Zin       = cw[CW_ZIN];
    assign HIin      = cw[CW_HIIN];
    assign LOin      = cw[CW_LOIN];
    assign CONin     = cw[CW_CONIN];
    assign OutPortIn = cw[CW_OUTPORTIN];
    assign Rin       = cw[CW_RIN];
    assign Gra       = cw[CW_GRA];
    assign Grb       = cw[CW_GRB];
    assign Grc       = cw[CW_GRC];
    assign Read      = cw[CW_READ];
    assign Write     = cw[CW_WRITE];
    assign ADD       = cw[CW_ADD];
    assign SUB       = cw[CW_SUB];
    assign AND       = cw[CW_AND];
    assign OR        = cw[CW_OR];
    assign SHR       = cw[CW_SHR];
    assign SHRA      = cw[CW_SHRA];
    assign SHL       = cw[CW_SHL];
    assign ROR       = cw[CW_ROR];
    assign ROL       = cw[CW_ROL];
    assign MUL       = cw[CW_MUL];
    assign DIV       = cw[CW_DIV];
    assign NEG       = cw[CW_NEG];
    assign NOT       = cw[CW_NOT];

endmodule
